// File: rtl/exp_arbiter_pkg.sv
// Shared definitions for the exp-unit arbiter: Q3.12 constants, clog2 and the
// requester tag carried alongside the exp pipeline.
package exp_arbiter_pkg;

   localparam int          DW   = 16;
   localparam int          FRAC = 12;
   localparam logic [15:0] ONE  = 16'd4096;

   // Widest requester id supported (N_REQ up to 8).
   localparam int ID_W = 3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/exp_arbiter_rr.sv
// Combinational round-robin pick: search starts at ptr and wraps; the first
// asserted request wins and the next pointer is the slot after the winner.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int TAG_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [TAG_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [TAG_W-1:0] idx,
   output logic [TAG_W-1:0] nxt_ptr,
   output logic             any
);

   logic [TAG_W:0]   cand_w;
   logic [TAG_W-1:0] cand;
   logic [TAG_W:0]   nxt_w;

   always_comb begin
      gnt    = '0;
      idx    = '0;
      any    = 1'b0;
      cand_w = '0;
      cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_w = {1'b0, ptr} + (TAG_W+1)'(k);
         if (cand_w >= (TAG_W+1)'(N_REQ)) cand_w = cand_w - (TAG_W+1)'(N_REQ);
         cand = cand_w[TAG_W-1:0];
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
      nxt_w = {1'b0, idx} + (TAG_W+1)'(1);
      if (nxt_w >= (TAG_W+1)'(N_REQ)) nxt_ptr = '0;
      else                            nxt_ptr = nxt_w[TAG_W-1:0];
   end

endmodule

// File: rtl/exp_arbiter.sv
// Shares one pipelined Q3.12 exp unit among N_REQ requesters, returning each
// result to its owner via a tag pipeline and flagging write-enable mismatches.
module exp_arbiter
   import exp_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DW      = 16,
   parameter int EXP_LAT = 3,
   parameter int TAG_W   = clog2(N_REQ)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_REQ-1:0]  req,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]  gnt,
   output logic [DW-1:0]     exp_data,
   input  logic [DW-1:0]     exp_out,
   input  logic              exp_we,
   output logic [N_REQ-1:0]  rsp_valid,
   output logic [DW-1:0]     rsp_data,
   output logic              busy,
   output logic              err
);

   logic [TAG_W-1:0] ptr;
   logic [N_REQ-1:0] arb_gnt;
   logic [TAG_W-1:0] arb_idx;
   logic [TAG_W-1:0] arb_nxt;
   logic             arb_any;

   // Stage 0 is written with the grant; stage EXP_LAT lines up with exp_we.
   tag_t tag_pipe [EXP_LAT+1];
   tag_t tag_out;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_rr (
      .req     (req),
      .ptr     (ptr),
      .gnt     (arb_gnt),
      .idx     (arb_idx),
      .nxt_ptr (arb_nxt),
      .any     (arb_any)
   );

   assign tag_out = tag_pipe[EXP_LAT];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr       <= '0;
         gnt       <= '0;
         exp_data  <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         err       <= 1'b0;
         for (int k = 0; k <= EXP_LAT; k++) tag_pipe[k] <= '0;
      end else begin
         // Issue stage
         gnt <= arb_any ? arb_gnt : '0;
         if (arb_any) begin
            exp_data <= req_data[arb_idx*DW +: DW];
            ptr      <= arb_nxt;
         end
         tag_pipe[0] <= '{valid: arb_any, id: ID_W'(arb_idx)};
         for (int k = 1; k <= EXP_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];

         // Return stage
         if (tag_out.valid && exp_we) begin
            rsp_valid <= N_REQ'(1) << tag_out.id;
            rsp_data  <= exp_out;
         end else begin
            rsp_valid <= '0;
         end
         if (tag_out.valid != exp_we) err <= 1'b1;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k <= EXP_LAT; k++) busy = busy | tag_pipe[k].valid;
   end

endmodule
